cpu_mem_wb: RTL

- Memory-access and writeback stage, directly downstream of the ALU execute function.
- Accepts one executed instruction per handshake and performs the data-bus transaction for store/load.
- Writes the register file, commits the architectural PC, and takes interrupts at instruction boundaries.
- Output drives the fetch PC and the register file of the single-issue core.

---
 rtl/cpu_mem_wb.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_wb.sv
// Memory-access / writeback stage: accepts one executed instruction, runs the
// data-bus transaction for sw/lw, writes the register file and commits the PC.
//
// state  | meaning
// IDLE   | ready for the next executed instruction
// BUS    | waiting for bus_ack on a sw/lw, timeout counter running
// COMMIT | single retire cycle: rf write, PC update, interrupt entry
module cpu_mem_wb #(
    parameter logic [31:0] INTR_VEC    = 32'h0000_0010,
    parameter int          BUS_TIMEOUT = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_opcode,
    input  logic [3:0]  ex_rd,
    input  logic [31:0] ex_x_rd,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_val,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic        commit,
    input  logic        intr_req,
    output logic        intr_ack,
    output logic        intr_en,
    output logic [31:0] epc,
    output logic        bus_err,
    input  logic        intr_en_set
);

    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

    localparam logic [3:0] OP_CALCI = 4'd1;
    localparam logic [3:0] OP_CALCR = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_JALR  = 4'd5;
    localparam logic [3:0] OP_JCC   = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_COMMIT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [3:0]    rd_q, rd_d;
    logic [31:0]   wb_q, wb_d;
    logic [31:0]   npc_q, npc_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   val_q, val_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_ok_q, wr_ok_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   epc_q, epc_d;
    logic          intr_en_q, intr_en_d;
    logic          bus_err_q, bus_err_d;
    logic          take_intr;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op == OP_CALCI) || (op == OP_CALCR) || (op == OP_LW) ||
               (op == OP_JALR)  || (op == OP_JCC);
    endfunction

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        wb_d      = wb_q;
        npc_d     = npc_q;
        addr_d    = addr_q;
        val_d     = val_q;
        cnt_d     = cnt_q;
        wr_ok_d   = wr_ok_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        bus_err_d = bus_err_q;
        ex_ready  = 1'b0;
        bus_req   = 1'b0;
        commit    = 1'b0;
        rf_we     = 1'b0;
        take_intr = 1'b0;

        case (state_q)
            S_IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid) begin
                    op_d    = ex_opcode;
                    rd_d    = ex_rd;
                    wb_d    = ex_x_rd;
                    npc_d   = ex_pc;
                    addr_d  = ex_mem_addr;
                    val_d   = ex_mem_val;
                    wr_ok_d = 1'b1;
                    cnt_d   = '0;
                    state_d = (ex_opcode == OP_SW || ex_opcode == OP_LW) ? S_BUS : S_COMMIT;
                end
            end
            S_BUS: begin
                bus_req = 1'b1;
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (bus_ack) begin
                    if (op_q == OP_LW) wb_d = bus_rdata;
                    cnt_d   = '0;
                    state_d = S_COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    wr_ok_d   = 1'b0;
                    state_d   = S_COMMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_COMMIT: begin
                commit    = 1'b1;
                rf_we     = writes_rd(op_q) && (rd_q != 4'd0) && wr_ok_q;
                take_intr = intr_req && intr_en_q;
                pc_d      = take_intr ? INTR_VEC : npc_q;
                if (take_intr) epc_d = npc_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Interrupt entry clears the enable even if a re-enable arrives together.
        intr_en_d = intr_en_q;
        if (intr_en_set) intr_en_d = 1'b1;
        if (take_intr)   intr_en_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            wb_q      <= '0;
            npc_q     <= '0;
            addr_q    <= '0;
            val_q     <= '0;
            cnt_q     <= '0;
            wr_ok_q   <= 1'b0;
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            intr_en_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            wb_q      <= wb_d;
            npc_q     <= npc_d;
            addr_q    <= addr_d;
            val_q     <= val_d;
            cnt_q     <= cnt_d;
            wr_ok_q   <= wr_ok_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            intr_en_q <= intr_en_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_we    = (op_q == OP_SW);
    assign bus_addr  = addr_q;
    assign bus_wdata = val_q;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = wb_q;
    assign pc        = pc_q;
    assign epc       = epc_q;
    assign intr_en   = intr_en_q;
    assign bus_err   = bus_err_q;
    assign intr_ack  = take_intr;

endmodule
